mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter_if.sv | 26 ++
 rtl/mux2_arbiter.sv | 120 ++++++++++++
 tb/tb_mux2_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_if.sv
// Bundle of the two 4-phase request/ack source ports and the valid/ready output channel.
// master: the arbiter side; slave: the producers/consumer side.
interface mux2_arbiter_if #(
  parameter int W = 8
);
  logic         req0;
  logic         req1;
  logic [W-1:0] x0;
  logic [W-1:0] x1;
  logic         ack0;
  logic         ack1;
  logic         b0;
  logic [W-1:0] z;
  logic         out_valid;
  logic         out_ready;

  modport master (
    input  req0, req1, x0, x1, out_ready,
    output ack0, ack1, b0, z, out_valid
  );

  modport slave (
    output req0, req1, x0, x1, out_ready,
    input  ack0, ack1, b0, z, out_valid
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-source arbiter driving a 2:1 mux select, registered output word and per-source 4-phase acks.
// Tie resolution: round-robin when MUX2_ARBITER_ROUND_ROBIN_EN is defined, else fixed priority to source 0.
module mux2_arbiter #(
  parameter int W = 8
) (
  input  logic            clock,
  input  logic            reset_,
  mux2_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic         b0_q, b0_d;
  logic         out_valid_q, out_valid_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic [W-1:0] z_q, z_d;
  logic         win_s;
  logic         req_w_s;

  // Winner among the currently raised requests; b0_q remembers it for the rest of the transaction.
  always_comb begin
    win_s = 1'b0;
    case ({bus.req1, bus.req0})
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
`ifdef MUX2_ARBITER_ROUND_ROBIN_EN
      2'b11:   win_s = ~last_q;
`else
      2'b11:   win_s = 1'b0;
`endif
      default: win_s = 1'b0;
    endcase
    req_w_s = b0_q ? bus.req1 : bus.req0;
  end

  // Next-state and next-output computation for the IDLE/SEND/ACK sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    b0_d        = b0_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          b0_d        = win_s;
          z_d         = win_s ? bus.x1 : bus.x0;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          ack0_d      = ~b0_q;
          ack1_d      = b0_q;
          state_d     = S_ACK;
        end else begin
          state_d = S_SEND;
        end
      end
      S_ACK: begin
        // A request dropped early (during SEND) makes this a one-cycle ack pulse.
        if (!req_w_s) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          last_d  = b0_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without acking it.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      b0_q        <= 1'b0;
      z_q         <= {W{1'b0}};
      out_valid_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      b0_q        <= b0_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign bus.b0        = b0_q;
  assign bus.z         = z_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration model; a negedge monitor checks every word the DUT presents.
module tb_mux2_arbiter;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } exp_t;

  logic clock;
  logic reset_;
  mux2_arbiter_if #(.W(8)) bus ();

  mux2_arbiter #(.W(8)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];
  logic [1:0] pend;
  logic [7:0] dat [2];
  bit         last_m;
  bit         rnd_cons;
  logic       or_dir;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    bus.req0 = pend[0];
    bus.req1 = pend[1];
    bus.x0   = dat[0];
    bus.x1   = dat[1];
  endtask

  function automatic logic ackof(input bit w);
    return w ? bus.ack1 : bus.ack0;
  endfunction

  // Reference arbitration: a lone requester wins; a tie goes by the configured policy.
  function automatic bit pick(input logic [1:0] p, input bit last);
    if (p == 2'b11) begin
`ifdef MUX2_ARBITER_ROUND_ROBIN_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return p[1];
  endfunction

  // One full transaction for the predicted winner, optionally dropping its request during SEND.
  task automatic run_txn(input bit drop_early);
    bit w;
    bit got;
    bit dropped;
    int h;
    w = pick(pend, last_m);
    exp_q.push_back({w, dat[w]});
    got = 1'b0;
    dropped = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      cyc();
      if (ackof(w) === 1'b1) got = 1'b1;
      else if (drop_early && bus.out_valid === 1'b1 && !dropped) begin
        pend[w] = 1'b0;
        drive();
        dropped = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: actual=no ack required=ack%0d within 200 cycles", w);
      pend[w] = 1'b0;
      drive();
      return;
    end
    if (dropped) begin
      cyc();
      chk("ack_pulse_1cyc", 32'(ackof(w)), 32'd0);
    end else begin
      h = $urandom_range(0, 2);
      repeat (h) begin
        cyc();
        chk("ack_hold", 32'(ackof(w)), 32'd1);
      end
      pend[w] = 1'b0;
      drive();
      cyc();
      chk("ack_release", 32'(ackof(w)), 32'd0);
    end
    last_m = w;
  endtask

  // Consumer: random or directed ready, changed on the falling edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clock);
      bus.out_ready = rnd_cons ? 1'($urandom_range(0, 1)) : or_dir;
    end
  end

  // Monitor: pops the expected word whenever a new one appears and checks it is held until taken.
  initial begin
    logic       pv;
    logic [7:0] pz;
    logic       pb;
    exp_t       e;
    pv = 1'b0;
    pz = 8'h00;
    pb = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_ === 1'b1) begin
        chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
        if (bus.out_valid === 1'b1 && !pv) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_word: actual=z %0h b0 %0d required=no word", bus.z, bus.b0);
          end else begin
            e = exp_q.pop_front();
            chk("word_src_b0", 32'(bus.b0), 32'(e.src));
            chk("word_z", 32'(bus.z), 32'(e.data));
          end
        end else if (bus.out_valid === 1'b1 && pv) begin
          chk("z_held", 32'(bus.z), 32'(pz));
          chk("b0_held", 32'(bus.b0), 32'(pb));
        end
      end
      pv = bus.out_valid;
      pz = bus.z;
      pb = bus.b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rnd_cons = 1'b0;
    or_dir   = 1'b0;
    pend     = 2'b00;
    dat[0]   = 8'h00;
    dat[1]   = 8'h00;
    last_m   = 1'b1;
    drive();
    reset_ = 1'b0;
    repeat (3) cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ack0", 32'(bus.ack0), 32'd0);
    chk("rst_ack1", 32'(bus.ack1), 32'd0);
    chk("rst_b0", 32'(bus.b0), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    reset_ = 1'b1;
    cyc();

    // Reset while a word from source 0 is waiting in SEND.
    pend = 2'b01; dat[0] = 8'h5C; drive();
    exp_q.push_back({1'b0, 8'h5C});
    cyc();
    chk("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    reset_ = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ack0", 32'(bus.ack0), 32'd0);
    chk("midrst_b0", 32'(bus.b0), 32'd0);
    chk("midrst_z", 32'(bus.z), 32'd0);
    pend = 2'b00; drive();
    cyc();
    reset_ = 1'b1;
    last_m = 1'b1;
    repeat (2) cyc();
    chk("postrst_idle", 32'(bus.out_valid), 32'd0);

    // Single source 1 with a 3-cycle consumer stall.
    pend = 2'b10; dat[1] = 8'hA5; drive();
    exp_q.push_back({1'b1, 8'hA5});
    cyc();
    chk("s1_valid", 32'(bus.out_valid), 32'd1);
    chk("s1_b0", 32'(bus.b0), 32'd1);
    chk("s1_z", 32'(bus.z), 32'hA5);
    repeat (3) begin
      cyc();
      chk("s1_stall_z", 32'(bus.z), 32'hA5);
      chk("s1_stall_ack1", 32'(bus.ack1), 32'd0);
    end
    or_dir = 1'b1;
    cyc();
    chk("s1_ack1_rise", 32'(bus.ack1), 32'd1);
    chk("s1_valid_fall", 32'(bus.out_valid), 32'd0);
    or_dir = 1'b0;
    pend = 2'b00; drive();
    cyc();
    chk("s1_ack1_fall", 32'(bus.ack1), 32'd0);
    last_m = 1'b1;

    // Stalled consumer while source 1 requests late; source 1 must wait its turn.
    pend = 2'b01; dat[0] = 8'h3C; drive();
    exp_q.push_back({1'b0, 8'h3C});
    cyc();
    chk("late_b0_grant", 32'(bus.b0), 32'd0);
    pend = 2'b11; dat[1] = 8'hC3; drive();
    exp_q.push_back({1'b1, 8'hC3});
    repeat (5) begin
      cyc();
      chk("late_b0_stable", 32'(bus.b0), 32'd0);
      chk("late_z_stable", 32'(bus.z), 32'h3C);
    end
    or_dir = 1'b1;
    cyc();
    chk("late_ack0_rise", 32'(bus.ack0), 32'd1);
    or_dir = 1'b0;
    pend = 2'b10; drive();
    cyc();
    chk("late_ack0_fall", 32'(bus.ack0), 32'd0);
    cyc();
    chk("late_s1_b0", 32'(bus.b0), 32'd1);
    chk("late_s1_valid", 32'(bus.out_valid), 32'd1);
    chk("late_s1_z", 32'(bus.z), 32'hC3);
    or_dir = 1'b1;
    cyc();
    chk("late_ack1_rise", 32'(bus.ack1), 32'd1);
    or_dir = 1'b0;
    pend = 2'b00; drive();
    cyc();
    chk("late_ack1_fall", 32'(bus.ack1), 32'd0);
    last_m = 1'b1;

    // Source 0 drops its request while its word is still unaccepted.
    pend = 2'b01; dat[0] = 8'h77; drive();
    exp_q.push_back({1'b0, 8'h77});
    cyc();
    chk("viol_valid", 32'(bus.out_valid), 32'd1);
    pend = 2'b00; drive();
    cyc();
    chk("viol_still_valid", 32'(bus.out_valid), 32'd1);
    chk("viol_no_ack_yet", 32'(bus.ack0), 32'd0);
    or_dir = 1'b1;
    cyc();
    chk("viol_ack0_rise", 32'(bus.ack0), 32'd1);
    chk("viol_valid_fall", 32'(bus.out_valid), 32'd0);
    or_dir = 1'b0;
    cyc();
    chk("viol_ack0_pulse", 32'(bus.ack0), 32'd0);
    cyc();
    chk("viol_back_idle", 32'(bus.out_valid), 32'd0);

    // Fresh reset so the tie sequence starts from last=1.
    reset_ = 1'b0;
    cyc();
    reset_ = 1'b1;
    last_m = 1'b1;
    rnd_cons = 1'b1;
    dat[0] = 8'h11;
    dat[1] = 8'h22;
    for (int i = 0; i < 4; i++) begin
      pend = 2'b11;
      drive();
      run_txn(1'b0);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b1;
    drive();
    run_txn(1'b0);

    // Randomized traffic; the model tracks pending requests and the last served source.
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && $urandom_range(0, 1) == 1) begin
          pend[s] = 1'b1;
          dat[s] = 8'($urandom);
        end
      end
      if (pend == 2'b00) begin
        int s2;
        s2 = $urandom_range(0, 1);
        pend[s2] = 1'b1;
        dat[s2] = 8'($urandom);
      end
      drive();
      run_txn($urandom_range(0, 3) == 0);
    end

    rnd_cons = 1'b0;
    pend = 2'b00;
    drive();
    repeat (5) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
